// File: rtl/cnn_layer_accel_load_pkg.sv
// Shared types for the octo load sequencer: FSM states, geometry record and
// the number of sequence words generated per output column.
package cnn_layer_accel_load_pkg;

  localparam int SEQ_WORDS_PER_COL = 5;
  localparam int GEOM_W            = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CFG    = 3'd1,
    ST_NEWMAP = 3'd2,
    ST_SEQ    = 3'd3,
    ST_PIX    = 3'd4,
    ST_DONE   = 3'd5
  } load_state_e;

  typedef struct packed {
    logic [GEOM_W-1:0] rows;
    logic [GEOM_W-1:0] cols;
    logic [GEOM_W-1:0] kernel;
  } geom_t;

endpackage

// File: rtl/cnn_layer_accel_rd_skid.sv
// Two-entry buffer behind a 1-cycle-latency memory read. The arriving word is
// bypassed straight to the output when the buffer is empty.
module cnn_layer_accel_rd_skid #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_can_issue,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_buf [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic         r_in_flight;
  logic [1:0]   r_count;
  logic         w_buf_empty;
  logic         w_write;
  logic         w_pop_buf;

  assign w_buf_empty = (r_count == 2'd0);
  // An arriving word only skips the buffer when it is consumed on arrival.
  assign w_write     = r_in_flight && !(w_buf_empty && i_pop);
  assign w_pop_buf   = i_pop && !w_buf_empty;
  assign o_valid     = !w_buf_empty || r_in_flight;
  assign o_data      = w_buf_empty ? i_data : r_buf[r_rd_ptr];
  assign o_can_issue = (({1'b0, r_count} + {2'b00, r_in_flight}) < 3'd2);

  // Buffer storage, pointers, occupancy and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf[0]    <= '0;
      r_buf[1]    <= '0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_in_flight <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_in_flight <= i_push;
      if (w_write) begin
        r_buf[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_buf) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_write} - {1'b0, w_pop_buf};
    end
  end

endmodule

// File: rtl/cnn_layer_accel_octo_load_ctrl.sv
// Loads one input map into a cnn_layer_accel_octo: derives the BRAM config,
// pulses new_map, then streams the sequence table and the pixel map onto datain.
module cnn_layer_accel_octo_load_ctrl
  import cnn_layer_accel_load_pkg::*;
#(
  parameter int C_PIXEL_WIDTH    = 16,
  parameter int C_SEQ_DATA_WIDTH = 13,
  parameter int C_DIM_WIDTH      = 10,
  parameter int C_ADDR_WIDTH     = 16
) (
  input  logic                        clk_500MHz,
  input  logic                        rst,
  input  logic                        start,
  input  logic [C_DIM_WIDTH-1:0]      rows,
  input  logic [C_DIM_WIDTH-1:0]      cols,
  input  logic [C_DIM_WIDTH-1:0]      kernel,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err,
  output logic [C_DIM_WIDTH-1:0]      num_input_rows_cfg,
  output logic [C_DIM_WIDTH-1:0]      num_input_cols_cfg,
  output logic [C_DIM_WIDTH-1:0]      num_output_rows_cfg,
  output logic [C_DIM_WIDTH-1:0]      num_output_cols_cfg,
  output logic [C_DIM_WIDTH+2:0]      seq_full_count_cfg,
  output logic [C_DIM_WIDTH+2:0]      row_matric_done_count_cfg,
  output logic                        new_map,
  output logic [C_ADDR_WIDTH-1:0]     seq_rd_addr,
  output logic                        seq_rd_en,
  input  logic [C_SEQ_DATA_WIDTH-1:0] seq_rd_data,
  output logic [C_ADDR_WIDTH-1:0]     pix_rd_addr,
  output logic                        pix_rd_en,
  input  logic [C_PIXEL_WIDTH-1:0]    pix_rd_data,
  output logic [C_PIXEL_WIDTH-1:0]    datain,
  output logic                        datain_valid,
  output logic                        seq_datain_tag,
  output logic                        pixel_datain_tag,
  input  logic                        seq_datain_rdy,
  input  logic                        pixel_datain_rdy
);

  localparam int CFG_W  = C_DIM_WIDTH + 3;
  localparam int CNT_W  = 2 * C_DIM_WIDTH;
  localparam int SKID_W = C_PIXEL_WIDTH + 1;

  load_state_e             r_state;
  load_state_e             w_state_next;
  geom_t                   r_geom;
  logic                    r_cfg_err;
  logic [C_DIM_WIDTH-1:0]  r_in_rows;
  logic [C_DIM_WIDTH-1:0]  r_in_cols;
  logic [C_DIM_WIDTH-1:0]  r_out_rows;
  logic [C_DIM_WIDTH-1:0]  r_out_cols;
  logic [CFG_W-1:0]        r_seq_full;
  logic [CFG_W-1:0]        r_row_done;
  logic [CNT_W-1:0]        r_pix_total;
  logic [CNT_W-1:0]        r_issue_cnt;
  logic [CNT_W-1:0]        r_xfer_cnt;

  logic [C_DIM_WIDTH-1:0]  w_rows;
  logic [C_DIM_WIDTH-1:0]  w_cols;
  logic [C_DIM_WIDTH-1:0]  w_kernel;
  logic                    w_geom_ok;
  logic                    w_idle_start;
  logic                    w_phase_act;
  logic [CNT_W-1:0]        w_total;
  logic                    w_can_issue;
  logic                    w_rd_req;
  logic [SKID_W-1:0]       w_skid_in;
  logic                    w_skid_valid;
  logic [SKID_W-1:0]       w_skid_data;
  logic                    w_tag_pix;
  logic                    w_rdy;
  logic                    w_xfer;
  logic                    w_last;

  assign w_rows       = C_DIM_WIDTH'(r_geom.rows);
  assign w_cols       = C_DIM_WIDTH'(r_geom.cols);
  assign w_kernel     = C_DIM_WIDTH'(r_geom.kernel);
  assign w_geom_ok    = (kernel != {C_DIM_WIDTH{1'b0}}) && (kernel <= rows) && (kernel <= cols);
  assign w_idle_start = (r_state == ST_IDLE) && start;

  assign w_phase_act  = (r_state == ST_SEQ) || (r_state == ST_PIX);
  assign w_total      = (r_state == ST_PIX) ? r_pix_total : CNT_W'(r_seq_full);
  assign w_rd_req     = w_phase_act && w_can_issue && (r_issue_cnt < w_total);

  // Both phases share the buffer; the top bit carries the pixel tag.
  assign w_skid_in    = (r_state == ST_PIX) ? {1'b1, pix_rd_data}
                                            : {1'b0, C_PIXEL_WIDTH'(seq_rd_data)};
  assign w_tag_pix    = w_skid_data[C_PIXEL_WIDTH];
  assign w_rdy        = w_tag_pix ? pixel_datain_rdy : seq_datain_rdy;
  assign w_xfer       = w_skid_valid && w_rdy;
  assign w_last       = w_xfer && (r_xfer_cnt == (w_total - CNT_W'(1)));

  cnn_layer_accel_rd_skid #(
    .W (SKID_W)
  ) u_rd_skid (
    .clk         (clk_500MHz),
    .rst         (rst),
    .i_push      (w_rd_req),
    .i_data      (w_skid_in),
    .i_pop       (w_xfer),
    .o_can_issue (w_can_issue),
    .o_valid     (w_skid_valid),
    .o_data      (w_skid_data)
  );

  // State register.
  always_ff @(posedge clk_500MHz) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_idle_start && w_geom_ok) w_state_next = ST_CFG;
                 else                           w_state_next = ST_IDLE;
      ST_CFG:    w_state_next = ST_NEWMAP;
      ST_NEWMAP: w_state_next = ST_SEQ;
      ST_SEQ:    if (w_last) w_state_next = ST_PIX;
                 else        w_state_next = ST_SEQ;
      ST_PIX:    if (w_last) w_state_next = ST_DONE;
                 else        w_state_next = ST_PIX;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Geometry latch, config derivation and phase counters.
  always_ff @(posedge clk_500MHz) begin
    if (rst) begin
      r_geom      <= '0;
      r_cfg_err   <= 1'b0;
      r_in_rows   <= '0;
      r_in_cols   <= '0;
      r_out_rows  <= '0;
      r_out_cols  <= '0;
      r_seq_full  <= '0;
      r_row_done  <= '0;
      r_pix_total <= '0;
      r_issue_cnt <= '0;
      r_xfer_cnt  <= '0;
    end else begin
      r_cfg_err <= w_idle_start && !w_geom_ok;
      if (w_idle_start && w_geom_ok) begin
        r_geom.rows   <= GEOM_W'(rows);
        r_geom.cols   <= GEOM_W'(cols);
        r_geom.kernel <= GEOM_W'(kernel);
      end
      if (r_state == ST_CFG) begin
        r_in_rows   <= w_rows - C_DIM_WIDTH'(1);
        r_in_cols   <= w_cols - C_DIM_WIDTH'(1);
        r_out_rows  <= w_rows - w_kernel;
        r_out_cols  <= w_cols - w_kernel;
        r_seq_full  <= (CFG_W'(w_cols - w_kernel) + CFG_W'(1)) * CFG_W'(SEQ_WORDS_PER_COL);
        r_row_done  <= CFG_W'(w_cols);
        r_pix_total <= CNT_W'(w_rows) * CNT_W'(w_cols);
      end
      if (w_rd_req) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
      if (w_xfer) begin
        r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
      end
      // All reads of a phase are issued before its last word can transfer.
      if (w_last) begin
        r_issue_cnt <= '0;
        r_xfer_cnt  <= '0;
      end
    end
  end

  assign busy                      = (r_state != ST_IDLE);
  assign done                      = (r_state == ST_DONE);
  assign new_map                   = (r_state == ST_NEWMAP);
  assign cfg_err                   = r_cfg_err;
  assign num_input_rows_cfg        = r_in_rows;
  assign num_input_cols_cfg        = r_in_cols;
  assign num_output_rows_cfg       = r_out_rows;
  assign num_output_cols_cfg       = r_out_cols;
  assign seq_full_count_cfg        = r_seq_full;
  assign row_matric_done_count_cfg = r_row_done;
  assign seq_rd_en                 = w_rd_req && (r_state == ST_SEQ);
  assign pix_rd_en                 = w_rd_req && (r_state == ST_PIX);
  assign seq_rd_addr               = (r_state == ST_SEQ) ? C_ADDR_WIDTH'(r_issue_cnt) : '0;
  assign pix_rd_addr               = (r_state == ST_PIX) ? C_ADDR_WIDTH'(r_issue_cnt) : '0;
  assign datain_valid              = w_skid_valid;
  assign datain                    = w_skid_valid ? w_skid_data[C_PIXEL_WIDTH-1:0] : '0;
  assign seq_datain_tag            = w_skid_valid && !w_tag_pix;
  assign pixel_datain_tag          = w_skid_valid && w_tag_pix;

endmodule

// File: tb/tb_cnn_layer_accel_octo_load_ctrl.sv
// Directed bench for the octo load sequencer with modelled source memories.
module tb_cnn_layer_accel_octo_load_ctrl;

  localparam int PW = 16;
  localparam int SW = 13;
  localparam int DW = 10;
  localparam int AW = 16;

  logic          clk_500MHz = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] rows, cols, kernel;
  logic          busy, done, cfg_err, new_map;
  logic [DW-1:0] in_rows_cfg, in_cols_cfg, out_rows_cfg, out_cols_cfg;
  logic [DW+2:0] seq_full_cfg, row_done_cfg;
  logic [AW-1:0] seq_rd_addr, pix_rd_addr;
  logic          seq_rd_en, pix_rd_en;
  logic [SW-1:0] seq_rd_data;
  logic [PW-1:0] pix_rd_data;
  logic [PW-1:0] datain;
  logic          datain_valid, seq_tag, pix_tag;
  logic          seq_rdy, pix_rdy;

  int n_vec = 0, n_miscmp = 0;
  int cyc = 0, c0 = 0;
  bit rnd_rdy = 1'b0;
  logic [PW:0] q_words[$];
  int stab_err, tag_err, done_cnt, newmap_cnt, cfgerr_cnt, busy_cnt, pix_cnt;
  int first_rd, first_rd_addr, first_valid, done_cyc, newmap_cyc;
  logic prev_stall = 1'b0;
  logic [PW:0] prev_word = '0;

  cnn_layer_accel_octo_load_ctrl dut (
    .clk_500MHz(clk_500MHz), .rst(rst), .start(start),
    .rows(rows), .cols(cols), .kernel(kernel),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .num_input_rows_cfg(in_rows_cfg), .num_input_cols_cfg(in_cols_cfg),
    .num_output_rows_cfg(out_rows_cfg), .num_output_cols_cfg(out_cols_cfg),
    .seq_full_count_cfg(seq_full_cfg), .row_matric_done_count_cfg(row_done_cfg),
    .new_map(new_map),
    .seq_rd_addr(seq_rd_addr), .seq_rd_en(seq_rd_en), .seq_rd_data(seq_rd_data),
    .pix_rd_addr(pix_rd_addr), .pix_rd_en(pix_rd_en), .pix_rd_data(pix_rd_data),
    .datain(datain), .datain_valid(datain_valid),
    .seq_datain_tag(seq_tag), .pixel_datain_tag(pix_tag),
    .seq_datain_rdy(seq_rdy), .pixel_datain_rdy(pix_rdy)
  );

  always #5 clk_500MHz = ~clk_500MHz;

  function automatic logic [SW-1:0] seq_fn(int a);
    return SW'(a * 37 + 341);
  endfunction

  function automatic logic [PW-1:0] pix_fn(int a);
    return PW'(a * 263 + 4660) ^ 16'h5A5A;
  endfunction

  // Source memories: one-cycle read latency.
  always @(posedge clk_500MHz) begin
    if (seq_rd_en) seq_rd_data <= seq_fn(int'(seq_rd_addr));
    if (pix_rd_en) pix_rd_data <= pix_fn(int'(pix_rd_addr));
  end

  initial forever begin
    @(posedge clk_500MHz);
    cyc = cyc + 1;
  end

  initial begin
    seq_rdy = 1'b1;
    pix_rdy = 1'b1;
    forever begin
      @(posedge clk_500MHz);
      #1;
      seq_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Observes the datain bus and event pulses away from the active edge.
  initial forever begin
    logic [PW:0] cur;
    logic rdy;
    int rel;
    @(negedge clk_500MHz);
    rel = cyc - c0;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      cur = {pix_tag, datain};
      rdy = pix_tag ? pix_rdy : seq_rdy;
      if (datain_valid) begin
        if (({1'b0, seq_tag} + {1'b0, pix_tag}) != 2'd1) tag_err++;
      end else if (seq_tag || pix_tag || (datain != '0)) begin
        tag_err++;
      end
      if (prev_stall && (!datain_valid || cur != prev_word)) stab_err++;
      prev_stall = datain_valid && !rdy;
      prev_word  = cur;
      if (datain_valid && rdy) begin
        q_words.push_back(cur);
        if (pix_tag) pix_cnt++;
      end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = rel; end
      if (new_map) begin newmap_cnt++; if (newmap_cyc < 0) newmap_cyc = rel; end
      if (cfg_err) cfgerr_cnt++;
      if (busy) busy_cnt++;
      if (seq_rd_en && first_rd < 0) begin first_rd = rel; first_rd_addr = int'(seq_rd_addr); end
      if (datain_valid && first_valid < 0) first_valid = rel;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    q_words.delete();
    stab_err = 0; tag_err = 0; done_cnt = 0; newmap_cnt = 0; cfgerr_cnt = 0;
    busy_cnt = 0; pix_cnt = 0;
    first_rd = -1; first_rd_addr = -1; first_valid = -1; done_cyc = -1; newmap_cyc = -1;
  endtask

  task automatic pulse_start(input int r, input int c, input int k);
    @(posedge clk_500MHz);
    #1;
    rows = DW'(r); cols = DW'(c); kernel = DW'(k);
    start = 1'b1;
    @(posedge clk_500MHz);
    #1;
    start = 1'b0;
  endtask

  task automatic start_run(input int r, input int c, input int k);
    @(posedge clk_500MHz);
    #1;
    clear_mon();
    c0 = cyc;
    rows = DW'(r); cols = DW'(c); kernel = DW'(k);
    start = 1'b1;
    @(posedge clk_500MHz);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk_500MHz);
      if (done) break;
    end
    check_eq({tag, "_done_seen"}, 32'(done), 32'd1);
    check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    @(negedge clk_500MHz);
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_cfg(input string tag, input int a, input int b, input int c,
                           input int d, input int e, input int f);
    check_eq({tag, "_in_rows"},  32'(in_rows_cfg),  32'(a));
    check_eq({tag, "_in_cols"},  32'(in_cols_cfg),  32'(b));
    check_eq({tag, "_out_rows"}, 32'(out_rows_cfg), 32'(c));
    check_eq({tag, "_out_cols"}, 32'(out_cols_cfg), 32'(d));
    check_eq({tag, "_seq_full"}, 32'(seq_full_cfg), 32'(e));
    check_eq({tag, "_row_done"}, 32'(row_done_cfg), 32'(f));
  endtask

  task automatic check_stream(input string tag, input int r, input int c, input int k);
    int nseq, ntot;
    logic [PW:0] exp_w;
    nseq = (c - k + 1) * 5;
    ntot = nseq + r * c;
    check_eq({tag, "_word_count"}, 32'(q_words.size()), 32'(ntot));
    for (int i = 0; i < ntot && i < q_words.size(); i++) begin
      exp_w = (i < nseq) ? {1'b0, 3'b000, seq_fn(i)} : {1'b1, pix_fn(i - nseq)};
      check_eq($sformatf("%s_word%0d", tag, i), 32'(q_words[i]), 32'(exp_w));
    end
    check_eq({tag, "_stall_stable"}, 32'(stab_err), 32'd0);
    check_eq({tag, "_tag_rule"},     32'(tag_err),  32'd0);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ctl"}, {24'd0, busy, done, cfg_err, new_map, seq_rd_en, pix_rd_en,
                             datain_valid, seq_tag | pix_tag}, 32'd0);
    check_eq({tag, "_cfg"}, 32'(in_rows_cfg | in_cols_cfg | out_rows_cfg | out_cols_cfg)
                            | 32'(seq_full_cfg | row_done_cfg), 32'd0);
    check_eq({tag, "_addr"}, {seq_rd_addr, pix_rd_addr}, 32'd0);
    check_eq({tag, "_datain"}, 32'(datain), 32'd0);
  endtask

  initial begin
    int bad_r [3] = '{10, 4, 4};
    int bad_c [3] = '{10, 4, 8};
    int bad_k [3] = '{11, 0, 5};
    int i;
    rst = 1'b1; start = 1'b0; rows = '0; cols = '0; kernel = '0;
    clear_mon();
    repeat (3) @(posedge clk_500MHz);
    #1;
    rst = 1'b0;
    @(negedge clk_500MHz);
    check_zero("reset");

    // Nominal 10x10 k=3 with ready high.
    start_run(10, 10, 3);
    wait_done("nom", 2000);
    check_eq("nom_done_cycle", 32'(done_cyc), 32'd145);
    check_eq("nom_newmap_cycle", 32'(newmap_cyc), 32'd2);
    check_eq("nom_first_rd_cycle", 32'(first_rd), 32'd3);
    check_eq("nom_first_rd_addr", 32'(first_rd_addr), 32'd0);
    check_eq("nom_first_valid_cycle", 32'(first_valid), 32'd4);
    check_eq("nom_done_count", 32'(done_cnt), 32'd1);
    check_eq("nom_newmap_count", 32'(newmap_cnt), 32'd1);
    check_cfg("nom", 9, 9, 7, 7, 40, 10);
    check_stream("nom", 10, 10, 3);

    // Same geometry with random backpressure on both readies.
    rnd_rdy = 1'b1;
    start_run(10, 10, 3);
    wait_done("bp", 4000);
    rnd_rdy = 1'b0;
    check_eq("bp_done_count", 32'(done_cnt), 32'd1);
    check_stream("bp", 10, 10, 3);

    // Rejected geometries: cfg_err only, config untouched.
    for (int v = 0; v < 3; v++) begin
      @(posedge clk_500MHz);
      #1;
      clear_mon();
      pulse_start(bad_r[v], bad_c[v], bad_k[v]);
      repeat (6) @(negedge clk_500MHz);
      check_eq($sformatf("bad%0d_cfg_err", v), 32'(cfgerr_cnt), 32'd1);
      check_eq($sformatf("bad%0d_busy", v), 32'(busy_cnt), 32'd0);
      check_eq($sformatf("bad%0d_new_map", v), 32'(newmap_cnt), 32'd0);
    end
    check_cfg("bad", 9, 9, 7, 7, 40, 10);

    // Start during PIX is ignored.
    start_run(4, 5, 2);
    for (i = 0; i < 500 && pix_cnt == 0; i++) @(posedge clk_500MHz);
    check_eq("busy_start_reached_pix", 32'(pix_cnt != 0), 32'd1);
    pulse_start(10, 10, 3);
    wait_done("busy_start", 1000);
    repeat (8) @(negedge clk_500MHz);
    check_eq("busy_start_done_count", 32'(done_cnt), 32'd1);
    check_eq("busy_start_newmap_count", 32'(newmap_cnt), 32'd1);
    check_cfg("busy_start", 3, 4, 2, 3, 20, 5);
    check_stream("busy_start", 4, 5, 2);

    // Reset in the middle of the sequence phase, then a 1x1 run.
    start_run(10, 10, 3);
    for (i = 0; i < 500 && q_words.size() < 20; i++) @(posedge clk_500MHz);
    check_eq("mid_rst_reached_20", 32'(q_words.size() >= 20), 32'd1);
    #1;
    rst = 1'b1;
    @(posedge clk_500MHz);
    #1;
    rst = 1'b0;
    @(negedge clk_500MHz);
    check_zero("mid_rst");
    start_run(1, 1, 1);
    wait_done("one", 200);
    check_eq("one_done_cycle", 32'(done_cyc), 32'd11);
    check_eq("one_first_rd_cycle", 32'(first_rd), 32'd3);
    check_eq("one_first_rd_addr", 32'(first_rd_addr), 32'd0);
    check_eq("one_done_count", 32'(done_cnt), 32'd1);
    check_cfg("one", 0, 0, 0, 0, 5, 1);
    check_stream("one", 1, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
